// File: rtl/sh7604_pkg.sv
// Shared types and constants for the SH7604 on-chip peripheral cluster.
package sh7604_pkg;

    localparam int DIV_W = 13;

    typedef enum logic [1:0] {
        RUN,
        PIN,
        WDT,
        STRETCH
    } rstc_state_t;

endpackage

// File: rtl/sh7604_rstc.sv
// Reset sequencer and peripheral prescaler: merges pin and watchdog reset sources into
// stretched, typed reset outputs and generates the CLKn_CE strobes.
module sh7604_rstc
    import sh7604_pkg::*;
#(
    parameter int HOLD_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic CE_R,
    input  logic RES_N,
    input  logic NMI_N,
    input  logic WDT_PRES,
    input  logic WDT_MRES,
    output logic CLK2_CE,
    output logic CLK8_CE,
    output logic CLK32_CE,
    output logic CLK64_CE,
    output logic CLK128_CE,
    output logic CLK256_CE,
    output logic CLK512_CE,
    output logic CLK1024_CE,
    output logic CLK4096_CE,
    output logic CLK8192_CE,
    output logic CPU_RES_N,
    output logic PER_RES_N,
    output logic WDT_RES_N,
    output logic RST_MANUAL,
    output logic RST_SRC_WDT
);

    localparam logic [7:0] CNT_LOAD = 8'(HOLD_CYCLES - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             res_m_q, res_m_d, res_s_q, res_s_d;
    logic             nmi_m_q, nmi_m_d, nmi_s_q, nmi_s_d;
    rstc_state_t      state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             manual_q, manual_d;
    logic             src_wdt_q, src_wdt_d;
    logic             cpu_res_n_q, cpu_res_n_d;
    logic             per_res_n_q, per_res_n_d;
    logic             wdt_res_n_q, wdt_res_n_d;

    always_comb begin
        div_d     = div_q;
        res_m_d   = res_m_q;
        res_s_d   = res_s_q;
        nmi_m_d   = nmi_m_q;
        nmi_s_d   = nmi_s_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        manual_d  = manual_q;
        src_wdt_d = src_wdt_q;

        if (CE_R) begin
            div_d   = div_q + 1'b1;
            res_m_d = RES_N;
            res_s_d = res_m_q;
            nmi_m_d = NMI_N;
            nmi_s_d = nmi_m_q;

            unique case (state_q)
                RUN: begin
                    if (!res_s_q) begin
                        state_d   = PIN;
                        manual_d  = ~nmi_s_q;
                        src_wdt_d = 1'b0;
                    end else if (WDT_PRES || WDT_MRES) begin
                        state_d   = WDT;
                        manual_d  = ~WDT_PRES;
                        src_wdt_d = 1'b1;
                    end
                end
                PIN: begin
                    if (res_s_q) begin
                        state_d = STRETCH;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        manual_d = ~nmi_s_q;
                    end
                end
                WDT: begin
                    state_d = STRETCH;
                    cnt_d   = CNT_LOAD;
                end
                STRETCH: begin
                    // A pin reset takes over a watchdog stretch; watchdog requests are ignored here.
                    if (!res_s_q) begin
                        state_d   = PIN;
                        manual_d  = ~nmi_s_q;
                        src_wdt_d = 1'b0;
                    end else if (cnt_q == 8'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            endcase
        end

        // Outputs are decoded from the next state so they change on the same edge as the state.
        cpu_res_n_d = (state_d == RUN);
        per_res_n_d = (state_d == RUN) | manual_d;
        wdt_res_n_d = (state_d == RUN) | manual_d | src_wdt_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q       <= '0;
            res_m_q     <= 1'b1;
            res_s_q     <= 1'b1;
            nmi_m_q     <= 1'b1;
            nmi_s_q     <= 1'b1;
            state_q     <= STRETCH;
            cnt_q       <= CNT_LOAD;
            manual_q    <= 1'b0;
            src_wdt_q   <= 1'b0;
            cpu_res_n_q <= 1'b0;
            per_res_n_q <= 1'b0;
            wdt_res_n_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            res_m_q     <= res_m_d;
            res_s_q     <= res_s_d;
            nmi_m_q     <= nmi_m_d;
            nmi_s_q     <= nmi_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            manual_q    <= manual_d;
            src_wdt_q   <= src_wdt_d;
            cpu_res_n_q <= cpu_res_n_d;
            per_res_n_q <= per_res_n_d;
            wdt_res_n_q <= wdt_res_n_d;
        end
    end

    assign CLK2_CE    = CE_R & (&div_q[0:0]);
    assign CLK8_CE    = CE_R & (&div_q[2:0]);
    assign CLK32_CE   = CE_R & (&div_q[4:0]);
    assign CLK64_CE   = CE_R & (&div_q[5:0]);
    assign CLK128_CE  = CE_R & (&div_q[6:0]);
    assign CLK256_CE  = CE_R & (&div_q[7:0]);
    assign CLK512_CE  = CE_R & (&div_q[8:0]);
    assign CLK1024_CE = CE_R & (&div_q[9:0]);
    assign CLK4096_CE = CE_R & (&div_q[11:0]);
    assign CLK8192_CE = CE_R & (&div_q[12:0]);

    assign CPU_RES_N   = cpu_res_n_q;
    assign PER_RES_N   = per_res_n_q;
    assign WDT_RES_N   = wdt_res_n_q;
    assign RST_MANUAL  = manual_q;
    assign RST_SRC_WDT = src_wdt_q;

endmodule
